// File: rtl/iterative_shift_register.sv
// Multi-mode iterative shift/rotate register: loads a word, then shifts or
// rotates it one bit per clock for AMOUNT steps, with BUSY/DONE handshake.
module iterative_shift_register #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in1_i,
  input  logic             load_enable_i,
  input  logic             start_i,
  input  logic [2:0]       mode_i,
  input  logic [AMT_W-1:0] amount_i,
  input  logic             serial_in_i,
  output logic [WIDTH-1:0] out_o,
  output logic             flag_o,
  output logic             zero_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [2:0] MODE_LSL  = 3'b000;
  localparam logic [2:0] MODE_LSR  = 3'b001;
  localparam logic [2:0] MODE_ASR  = 3'b010;
  localparam logic [2:0] MODE_ROL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_LSLS = 3'b101;
  localparam logic [2:0] MODE_LSRS = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FIN   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             flag_q, flag_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic [WIDTH-1:0] step_data;
  logic             step_flag;

  // One single-bit step of the captured operation; FLAG takes the exiting bit.
  always_comb begin
    step_data = data_q;
    step_flag = 1'b0;
    case (mode_q)
      MODE_LSL: begin
        step_data = {data_q[WIDTH-2:0], 1'b0};
        step_flag = data_q[WIDTH-1];
      end
      MODE_LSR: begin
        step_data = {1'b0, data_q[WIDTH-1:1]};
        step_flag = data_q[0];
      end
      MODE_ASR: begin
        step_data = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
        step_flag = data_q[0];
      end
      MODE_ROL: begin
        step_data = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
        step_flag = data_q[WIDTH-1];
      end
      MODE_ROR: begin
        step_data = {data_q[0], data_q[WIDTH-1:1]};
        step_flag = data_q[0];
      end
      MODE_LSLS: begin
        step_data = {data_q[WIDTH-2:0], serial_in_i};
        step_flag = data_q[WIDTH-1];
      end
      MODE_LSRS: begin
        step_data = {serial_in_i, data_q[WIDTH-1:1]};
        step_flag = data_q[0];
      end
      default: begin
        step_data = data_q;
        step_flag = 1'b0;
      end
    endcase
  end

  // Next-state logic; load wins over start, both ignored outside IDLE.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    flag_d  = flag_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (load_enable_i) begin
          data_d = in1_i;
          flag_d = 1'b0;
        end else if (start_i) begin
          if (amount_i == '0) begin
            state_d = ST_FIN;
          end else begin
            mode_d  = mode_i;
            cnt_d   = amount_i;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        data_d = step_data;
        flag_d = step_flag;
        cnt_d  = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      flag_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      flag_q  <= flag_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign out_o  = data_q;
  assign flag_o = flag_q;
  assign zero_o = (data_q == '0);
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_iterative_shift_register.sv
// Bench for iterative_shift_register: directed vector table, handshake corner
// sequences and randomized operations against a closed-form reference model.
module tb_iterative_shift_register;

  localparam int unsigned W = 4;
  localparam int unsigned A = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in1;
  logic         load_en, start, sin;
  logic [2:0]   mode;
  logic [A-1:0] amount;
  logic [W-1:0] out;
  logic         flag, zero, busy, done;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] md;
  logic         mf;

  iterative_shift_register #(.WIDTH(W), .AMT_W(A)) dut (
    .clk(clk), .rst_n(rst_n), .in1_i(in1), .load_enable_i(load_en),
    .start_i(start), .mode_i(mode), .amount_i(amount), .serial_in_i(sin),
    .out_o(out), .flag_o(flag), .zero_o(zero), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         reload;
    logic [W-1:0] load_val;
    logic [2:0]   mode;
    logic [A-1:0] amt;
    logic         sin;
    logic [W-1:0] exp_out;
    logic         exp_flag;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Result of n steps computed directly from the shift/rotate definitions.
  function automatic logic [W:0] model_op(input logic [W-1:0] d, input logic f,
                                          input logic [2:0] m, input int n, input logic s);
    logic [W-1:0] r, fillm;
    logic         fo, fill;
    int           k;
    r = d; fo = f; k = n % W;
    if (n == 0) return {d, f};
    case (m)
      3'd0, 3'd5: begin
        fill  = (m == 3'd5) && s;
        r     = (n >= W) ? '0 : W'(d << n);
        fillm = (n >= W) ? '1 : W'((32'd1 << n) - 32'd1);
        if (fill) r = r | fillm;
        fo = (n <= W) ? d[W-n] : fill;
      end
      3'd1, 3'd6: begin
        fill  = (m == 3'd6) && s;
        r     = (n >= W) ? '0 : W'(d >> n);
        fillm = (n >= W) ? '1 : ~W'({W{1'b1}} >> n);
        if (fill) r = r | fillm;
        fo = (n <= W) ? d[n-1] : fill;
      end
      3'd2: begin
        r  = W'($signed(d) >>> n);
        fo = (n <= W) ? d[n-1] : d[W-1];
      end
      3'd3: begin
        r  = W'((d << k) | (d >> (W - k)));
        fo = r[0];
      end
      3'd4: begin
        r  = W'((d >> k) | (d << (W - k)));
        fo = r[W-1];
      end
      default: begin
        r  = d;
        fo = 1'b0;
      end
    endcase
    return {r, fo};
  endfunction

  task automatic do_load(input logic [W-1:0] v);
    @(negedge clk); load_en = 1'b1; in1 = v;
    @(negedge clk); load_en = 1'b0; in1 = W'($urandom);
    check("load_out", 32'(out), 32'(v));
    check("load_flag", 32'(flag), 32'd0);
    md = v; mf = 1'b0;
  endtask

  // Issues START, scrambles MODE/AMOUNT after capture, waits (bounded) for DONE.
  task automatic run_op(input logic [2:0] m, input logic [A-1:0] a, input logic s,
                        output int lat, output int bcnt);
    @(negedge clk); start = 1'b1; mode = m; amount = a; sin = s;
    @(negedge clk); start = 1'b0; mode = 3'($urandom); amount = A'($urandom);
    lat = 1; bcnt = busy ? 1 : 0;
    while (!done && lat < 32) begin
      @(negedge clk); lat++;
      if (busy) bcnt++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=%0d required=%0d", lat, a + 1);
    end
  endtask

  task automatic op_and_check(input string tag, input logic [2:0] m, input logic [A-1:0] a,
                              input logic s, input logic [W-1:0] eo, input logic ef);
    int lat, bcnt;
    run_op(m, a, s, lat, bcnt);
    check({tag, "_out"}, 32'(out), 32'(eo));
    check({tag, "_flag"}, 32'(flag), 32'(ef));
    check({tag, "_zero"}, 32'(zero), 32'(eo == '0));
    check({tag, "_latency"}, 32'(lat), 32'(a) + 32'd1);
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'(a) + 32'd1);
    md = eo; mf = ef;
  endtask

  initial begin
    vec_t vecs[10];
    logic [W:0] exp;
    int lat;

    vecs[0] = '{1'b1, 4'b0010, 3'd1, 3'd1, 1'b0, 4'b0001, 1'b0};
    vecs[1] = '{1'b0, 4'b0000, 3'd1, 3'd1, 1'b0, 4'b0000, 1'b1};
    vecs[2] = '{1'b1, 4'b1011, 3'd2, 3'd2, 1'b0, 4'b1110, 1'b1};
    vecs[3] = '{1'b1, 4'b1001, 3'd3, 3'd3, 1'b0, 4'b1100, 1'b0};
    vecs[4] = '{1'b1, 4'b1001, 3'd4, 3'd5, 1'b0, 4'b1100, 1'b1};
    vecs[5] = '{1'b1, 4'b0000, 3'd5, 3'd3, 1'b1, 4'b0111, 1'b0};
    vecs[6] = '{1'b0, 4'b0000, 3'd0, 3'd7, 1'b0, 4'b0000, 1'b0};
    vecs[7] = '{1'b1, 4'b1010, 3'd7, 3'd2, 1'b1, 4'b1010, 1'b0};
    vecs[8] = '{1'b1, 4'b0110, 3'd2, 3'd7, 1'b0, 4'b0000, 1'b0};
    vecs[9] = '{1'b1, 4'b1000, 3'd6, 3'd2, 1'b0, 4'b0010, 1'b0};

    rst_n = 1'b0; in1 = '0; load_en = 1'b0; start = 1'b0; mode = '0; amount = '0; sin = 1'b0;
    md = '0; mf = 1'b0;
    #12;
    check("rst_out", 32'(out), 32'd0);
    check("rst_flag", 32'(flag), 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].reload) do_load(vecs[i].load_val);
      op_and_check($sformatf("vec%0d", i), vecs[i].mode, vecs[i].amt, vecs[i].sin,
                   vecs[i].exp_out, vecs[i].exp_flag);
    end
    @(negedge clk);
    check("post_done_low", 32'(done), 32'd0);
    check("post_busy_low", 32'(busy), 32'd0);

    // AMOUNT = 0: immediate DONE, data untouched
    do_load(4'b1101);
    op_and_check("amt0", 3'd0, 3'd0, 1'b0, 4'b1101, 1'b0);

    // LOAD_ENABLE and START together: load only
    @(negedge clk); load_en = 1'b1; start = 1'b1; in1 = 4'b0101; mode = 3'd1; amount = 3'd3;
    @(negedge clk); load_en = 1'b0; start = 1'b0;
    check("ldst_out", 32'(out), 32'b0101);
    check("ldst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("ldst_busy2", 32'(busy), 32'd0);
    check("ldst_done", 32'(done), 32'd0);

    // START/LOAD during SHIFT are ignored
    do_load(4'b0011);
    @(negedge clk); start = 1'b1; mode = 3'd3; amount = 3'd4;
    @(negedge clk); start = 1'b1; load_en = 1'b1; in1 = 4'b1111; mode = 3'd0; amount = 3'd1;
    @(negedge clk);
    @(negedge clk); start = 1'b0; load_en = 1'b0;
    lat = 0;
    while (!done && lat < 32) begin @(negedge clk); lat++; end
    check("busyign_done", 32'(done), 32'd1);
    check("busyign_out", 32'(out), 32'b0011);
    check("busyign_flag", 32'(flag), 32'd1);

    // Asynchronous reset in the middle of a long shift
    do_load(4'b1111);
    @(negedge clk); start = 1'b1; mode = 3'd0; amount = 3'd6;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out", 32'(out), 32'd0);
    check("arst_flag", 32'(flag), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_zero", 32'(zero), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    do_load(4'b0001);
    op_and_check("after_rst", 3'd0, 3'd2, 1'b0, 4'b0100, 1'b0);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [2:0] rm;
      logic [A-1:0] ra;
      logic rs;
      if ($urandom_range(2) == 0) do_load(W'($urandom));
      rm = 3'($urandom); ra = A'($urandom); rs = 1'($urandom);
      exp = model_op(md, mf, rm, int'(ra), rs);
      op_and_check($sformatf("rnd%0d_m%0d_a%0d", i, rm, ra), rm, ra, rs, exp[W:1], exp[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iterative_shift_register.md
Name: iterative_shift_register

Overview:
- Parametrised, multi-mode sequential shift register for the ALU datapath. Successor to the fixed 4-bit single-step shifter.
- Holds a WIDTH-bit data register and loads it from IN1.
- On START, performs a multi-bit shift or rotate of AMOUNT positions, one bit per clock.
- Reports completion with a BUSY/DONE handshake, plus carry-out (FLAG) and ZERO status to the flags logic.

Parameters:
WIDTH, 4, data register width in bits (>=2)
AMT_W, 3, width of AMOUNT; shift counts 0..2^AMT_W-1

Ports:
CLK  input  1  system clock, rising-edge active
RESET  input  1  asynchronous, active-low reset
IN1  input  WIDTH  parallel load data
LOAD_ENABLE  input  1  load IN1 into data register (IDLE only)
START  input  1  begin shift operation (IDLE only)
MODE  input  3  operation select, captured on START
AMOUNT  input  AMT_W  number of single-bit steps, captured on START
SERIAL_IN  input  1  fill bit for serial-fill modes
OUT  output  WIDTH  data register contents
FLAG  output  1  last bit shifted/rotated out
ZERO  output  1  high when OUT == 0
BUSY  output  1  operation in progress
DONE  output  1  one-cycle completion pulse

Behaviour:
- Reset (RESET low, asynchronous, effective immediately, including mid-operation):
  - data register = 0, FLAG = 0, BUSY = 0, DONE = 0, state = IDLE, internal counter = 0.
  - ZERO = 1.
- ZERO is combinational from the data register. All other outputs are registered.
- MODE encoding (one step):
  - 000 LSL, 0 fill.
  - 001 LSR, 0 fill.
  - 010 ASR, MSB replicated.
  - 011 ROL.
  - 100 ROR.
  - 101 LSL, SERIAL_IN fill.
  - 110 LSR, SERIAL_IN fill.
  - 111 reserved: each step leaves data unchanged and sets FLAG = 0.
- Each step sets FLAG to the bit leaving the register: the MSB for left operations, the LSB for right operations. Rotates update FLAG the same way.
- SERIAL_IN is sampled at every step edge, not captured at START.
- State machine: IDLE, SHIFT, FIN.
  - IDLE, LOAD_ENABLE = 1: data <= IN1, FLAG <= 0, stay IDLE. LOAD_ENABLE has priority; a simultaneous START is ignored.
  - IDLE, START = 1, AMOUNT = 0: no data change, go to FIN.
  - IDLE, START = 1, AMOUNT > 0: capture MODE, set count = AMOUNT, go to SHIFT.
  - SHIFT: perform one step per edge and decrement count. On the edge that performs the final step (count = 1), go to FIN.
  - FIN: DONE = 1 for exactly this cycle, then go to IDLE unconditionally.
- Handshake and outputs:
  - BUSY = 1 in SHIFT and FIN, 0 in IDLE.
  - START and LOAD_ENABLE are ignored while BUSY = 1.
  - MODE and AMOUNT changes after capture have no effect.
- Latency: with START sampled at edge 0, steps occur at edges 1..AMOUNT.
  - DONE rises after edge AMOUNT (or after edge 0 when AMOUNT = 0) and lasts one cycle.
  - OUT and FLAG hold the final result while DONE = 1.
- AMOUNT >= WIDTH is legal; all AMOUNT steps are executed.
  - Logical shifts saturate to 0 (or to all SERIAL_IN).
  - Rotates wrap modulo WIDTH.
  - ASR saturates to all-sign.
- Back-to-back operation: a new START is accepted in the IDLE cycle immediately following FIN.

Test Plan:
1. Load 0010, LSR AMOUNT = 1 -> OUT 0001, FLAG 0, ZERO 0. Repeat LSR AMOUNT = 1 -> OUT 0000, FLAG 1, ZERO 1.
2. Load 1011, ASR AMOUNT = 2 -> BUSY high 3 cycles (2 SHIFT + FIN); DONE pulse after edge 2; OUT 1110, FLAG 1.
3. Load 1001:
   - ROL AMOUNT = 3 -> OUT 1100, FLAG 0.
   - Reload 1001, ROR AMOUNT = 5 -> OUT 1100, FLAG 1 (wrap-around).
4. Load 0000, mode 101 with SERIAL_IN = 1, AMOUNT = 3 -> OUT 0111, FLAG 0. Then LSL AMOUNT = 7 -> OUT 0000, FLAG 0.
5. Handshake corner cases:
   - START with AMOUNT = 0 -> DONE on next cycle, OUT unchanged.
   - LOAD_ENABLE + START together with IN1 = 0101 -> OUT 0101, BUSY stays 0.
   - START and LOAD_ENABLE = 1 (IN1 = 1111) asserted during SHIFT -> no effect on the result.
6. Drive RESET low midway through LSL AMOUNT = 6 -> OUT 0000, FLAG 0, BUSY 0, DONE 0, ZERO 1 immediately without a clock edge. After RESET is released, a new START is accepted.
